// File: rtl/rect_pos_arbiter_pkg.sv
// Shared screen geometry, position type, FSM encoding and clamp helper
// for the sprite-position arbiter.
package rect_pos_arbiter_pkg;

    // Visible area (800x600 SVGA) and sprite size.
    localparam int unsigned HOR_PIXELS  = 800;
    localparam int unsigned VER_PIXELS  = 600;
    localparam int unsigned RECT_WIDTH  = 48;
    localparam int unsigned RECT_HEIGHT = 64;

    // Largest top-left corner that keeps the whole rect on screen.
    localparam logic [11:0] RECT_MAX_X = 12'(HOR_PIXELS - RECT_WIDTH);
    localparam logic [11:0] RECT_MAX_Y = 12'(VER_PIXELS - RECT_HEIGHT);

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } pos_t;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        COMMIT = 2'd1,
        SWAP   = 2'd2
    } state_t;

    // Unsigned saturation to the visible area; pass-through when en is 0.
    function automatic pos_t clamp_pos(input pos_t p, input bit en);
        pos_t r;
        r = p;
        if (en) begin
            if (p.x > RECT_MAX_X) r.x = RECT_MAX_X;
            if (p.y > RECT_MAX_Y) r.y = RECT_MAX_Y;
        end
        return r;
    endfunction

endpackage

// File: rtl/rect_pos_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts at rr_ptr and wraps.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] win_idx,
    output logic          any_req
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IW-1:0]  off;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl = {req, req} >> rr_ptr;
        req_rot = req_dbl[N-1:0];
        off     = '0;
        any_req = |req;
        for (int unsigned k = N; k > 0; k--) begin
            if (req_rot[k-1]) off = IW'(k - 1);
        end
        win_idx = IW'((int'(rr_ptr) + int'(off)) % int'(N));
    end

endmodule

// File: rtl/rect_pos_arbiter.sv
// Round-robin arbiter for sprite position updates with per-object shadow
// registers that are copied to the displayed outputs at vblank rise.
module rect_pos_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter bit          CLAMP_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vblnk,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*12-1:0]   req_xpos,
    input  logic [N_REQ*12-1:0]   req_ypos,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ*12-1:0]   xpos,
    output logic [N_REQ*12-1:0]   ypos,
    output logic                  frame_upd,
    output logic                  busy
);

    import rect_pos_arbiter_pkg::*;

    localparam int unsigned IW = $clog2(N_REQ);

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] arb_win;
    logic          any_req;
    logic          vblnk_prv;
    logic          vblnk_rise;
    logic          swap_pend;
    pos_t          shadow [N_REQ];
    pos_t          req_pos;
    pos_t          commit_pos;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win_idx (arb_win),
        .any_req (any_req)
    );

    assign vblnk_rise = vblnk & ~vblnk_prv;

    // Select the winner's data slice and clamp it for the shadow write.
    always_comb begin
        req_pos = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                req_pos.x = req_xpos[i*12 +: 12];
                req_pos.y = req_ypos[i*12 +: 12];
            end
        end
        commit_pos = clamp_pos(req_pos, CLAMP_EN);
    end

    // State register, winner latch, round-robin pointer and swap request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB;
            rr_ptr    <= '0;
            win_idx   <= '0;
            vblnk_prv <= 1'b0;
            swap_pend <= 1'b0;
        end else begin
            state_q   <= state_d;
            vblnk_prv <= vblnk;
            if (state_q == ARB && !swap_pend && any_req)
                win_idx <= arb_win;
            if (state_q == COMMIT)
                rr_ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            // A new rise wins over the clear so it is never lost.
            if (vblnk_rise)
                swap_pend <= 1'b1;
            else if (state_q == SWAP)
                swap_pend <= 1'b0;
        end
    end

    // Shadow writes on COMMIT; shadow-to-active copy on SWAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) shadow[i] <= '0;
            xpos <= '0;
            ypos <= '0;
        end else begin
            if (state_q == COMMIT) begin
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    if (win_idx == IW'(i)) shadow[i] <= commit_pos;
                end
            end
            if (state_q == SWAP) begin
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    xpos[i*12 +: 12] <= shadow[i].x;
                    ypos[i*12 +: 12] <= shadow[i].y;
                end
            end
        end
    end

    // Next state and per-state strobes; swap takes priority over requests.
    always_comb begin
        state_d   = state_q;
        gnt       = '0;
        frame_upd = 1'b0;
        case (state_q)
            ARB: begin
                if (swap_pend)    state_d = SWAP;
                else if (any_req) state_d = COMMIT;
            end
            COMMIT: begin
                for (int unsigned i = 0; i < N_REQ; i++)
                    gnt[i] = (win_idx == IW'(i));
                state_d = ARB;
            end
            SWAP: begin
                frame_upd = 1'b1;
                state_d   = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    assign busy = (state_q != ARB);

endmodule

// File: tb/tb_rect_pos_arbiter.sv
// Directed bench for rect_pos_arbiter: one clamping and one pass-through
// instance share the same stimulus.
module tb_rect_pos_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            vblnk;
    logic [N-1:0]    req;
    logic [N*12-1:0] req_xpos, req_ypos;
    logic [N-1:0]    gnt, gnt_nc;
    logic [N*12-1:0] xpos, ypos, xpos_nc, ypos_nc;
    logic            frame_upd, frame_upd_nc, busy, busy_nc;

    int errors = 0;
    int checks = 0;
    bit saw50  = 1'b0;

    always #5 clk = ~clk;

    rect_pos_arbiter #(.N_REQ(N), .CLAMP_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .req(req),
        .req_xpos(req_xpos), .req_ypos(req_ypos), .gnt(gnt),
        .xpos(xpos), .ypos(ypos), .frame_upd(frame_upd), .busy(busy)
    );

    rect_pos_arbiter #(.N_REQ(N), .CLAMP_EN(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .vblnk(vblnk), .req(req),
        .req_xpos(req_xpos), .req_ypos(req_ypos), .gnt(gnt_nc),
        .xpos(xpos_nc), .ypos(ypos_nc), .frame_upd(frame_upd_nc), .busy(busy_nc)
    );

    typedef struct {
        int idx;
        int x, y;
        int ex, ey;       // expected with clamping
        int ex_nc, ey_nc; // expected without clamping
    } vec_t;

    vec_t vt [6];

    function automatic logic [11:0] sl(input logic [N*12-1:0] v, input int i);
        return v[i*12 +: 12];
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sl(xpos, 3) == 12'd50 || sl(xpos_nc, 3) == 12'd50) saw50 = 1'b1;
    endtask

    // Raise req[idx] with data, wait (bounded) for the grant, then drop req.
    task automatic do_req(input int idx, input int x, input int y, input string nm);
        int  n;
        bit  seen;
        req[idx]               = 1'b1;
        req_xpos[idx*12 +: 12] = 12'(x);
        req_ypos[idx*12 +: 12] = 12'(y);
        n = 0; seen = 1'b0;
        while (!seen && n < 8) begin
            tick();
            n++;
            if (gnt != '0) seen = 1'b1;
        end
        check({nm, "_gnt_lat"}, n, 1);
        check({nm, "_gnt"}, gnt, 4'b0001 << idx);
        tick();
        req[idx] = 1'b0;
        check({nm, "_gnt_1cyc"}, gnt, 0);
    endtask

    // Hold vblnk high for 'hold' cycles, then low; count frame_upd pulses.
    task automatic pulse_vblank(input int hold, output int pulses, output int first);
        vblnk  = 1'b1;
        pulses = 0;
        first  = -1;
        for (int c = 1; c <= hold; c++) begin
            tick();
            if (frame_upd) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        vblnk = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (frame_upd) pulses++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p, f;
        int exp_g [5];

        vt[0] = '{1, 100,  200,  100, 200,  100,  200};
        vt[1] = '{2, 790,  590,  752, 536,  790,  590};
        vt[2] = '{3, 752,  536,  752, 536,  752,  536};
        vt[3] = '{0, 753,  537,  752, 536,  753,  537};
        vt[4] = '{0, 4095, 4095, 752, 536,  4095, 4095};
        vt[5] = '{2, 0,    0,    0,   0,    0,    0};

        rst = 1'b1; vblnk = 1'b0; req = '0; req_xpos = '0; req_ypos = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_xpos", xpos, 0);
        check("rst_ypos", ypos, 0);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_fupd", frame_upd, 0);
        rst = 1'b0;
        tick();

        // Table: request, wait for vblank swap, check displayed position.
        for (int i = 0; i < 6; i++) begin
            do_req(vt[i].idx, vt[i].x, vt[i].y, $sformatf("v%0d", i));
            pulse_vblank(4, p, f);
            check($sformatf("v%0d_pulses", i), p, 1);
            check($sformatf("v%0d_swap_lat", i), f, 2);
            check($sformatf("v%0d_x", i), sl(xpos, vt[i].idx), vt[i].ex);
            check($sformatf("v%0d_y", i), sl(ypos, vt[i].idx), vt[i].ey);
            check($sformatf("v%0d_x_nc", i), sl(xpos_nc, vt[i].idx), vt[i].ex_nc);
            check($sformatf("v%0d_y_nc", i), sl(ypos_nc, vt[i].idx), vt[i].ey_nc);
        end

        // Asynchronous reset mid-cycle clears displayed values at once.
        #3 rst = 1'b1;
        #1;
        check("arst_xpos", xpos, 0);
        check("arst_ypos", ypos, 0);
        check("arst_gnt", gnt, 0);
        check("arst_fupd", frame_upd, 0);
        check("arst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Contention: all four held, grants alternate with ARB cycles.
        exp_g = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c % 2 == 1)
                check($sformatf("rr_c%0d", c), gnt, 4'b0001 << exp_g[c/2]);
            else
                check($sformatf("rr_c%0d", c), gnt, 0);
        end
        req = 4'b0101;   // req[0] still held, pointer moves to 1
        tick();
        check("rr_gap", gnt, 0);
        tick();
        check("rr_skip", gnt, 4'b0100);
        req = '0;
        repeat (3) tick();

        // Reset during COMMIT: grant vanishes and nothing reaches shadow.
        req[1] = 1'b1;
        req_xpos[12 +: 12] = 12'd77;
        req_ypos[12 +: 12] = 12'd88;
        tick();
        check("mcr_gnt_pre", gnt, 4'b0010);
        check("mcr_busy_pre", busy, 1);
        #3 rst = 1'b1;
        #1;
        check("mcr_gnt", gnt, 0);
        check("mcr_busy", busy, 0);
        req[1] = 1'b0;
        rst = 1'b0;
        tick();
        pulse_vblank(4, p, f);
        check("mcr_pulses", p, 1);
        check("mcr_x", sl(xpos, 1), 0);
        check("mcr_y", sl(ypos, 1), 0);

        // vblank rises during COMMIT of 300: swap follows, held for 28 lines.
        req[0] = 1'b1;
        req_xpos[0 +: 12] = 12'd300;
        req_ypos[0 +: 12] = 12'd20;
        tick();
        check("vc_gnt", gnt, 4'b0001);
        vblnk = 1'b1;
        tick();
        req[0] = 1'b0;
        pulse_vblank(28 * 1056, p, f);
        check("vc_pulses", p, 1);
        check("vc_swap_next", f, 1);
        check("vc_x", sl(xpos, 0), 300);
        check("vc_y", sl(ypos, 0), 20);

        // Two updates in one frame: only the last one is ever displayed.
        saw50 = 1'b0;
        do_req(3, 50, 5, "mf50");
        repeat (3) tick();
        check("mf_hold1", sl(xpos, 3), 0);
        do_req(3, 60, 6, "mf60");
        check("mf_hold2", sl(xpos, 3), 0);
        pulse_vblank(4, p, f);
        check("mf_pulses", p, 1);
        check("mf_x", sl(xpos, 3), 60);
        check("mf_y", sl(ypos, 3), 6);
        check("mf_no50", saw50, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
